// File: rtl/corridor_light_pkg.sv
// corridor_light_pkg: shared zone state encoding and default timing for the corridor lighting controller.
package corridor_light_pkg;
    typedef enum logic [1:0] {IDLE, DEB, ON, HOLD} zone_state_t;
    localparam int STATE_W      = 2;
    localparam int DEB_W        = 4;
    localparam int DEF_N_CH     = 3;
    localparam int DEF_DEB_CYC  = 4;
    localparam int DEF_ON_CYC   = 80;
    localparam int DEF_HOLD_CYC = 40;
    localparam int DEF_CNT_W    = 8;
endpackage

// File: rtl/corridor_light_zone.sv
// corridor_light_zone: one zone's debounce, on/hold timer, eco hand-off and start pulse.
module corridor_light_zone
    import corridor_light_pkg::*;
#(
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int ON_CYC   = DEF_ON_CYC,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic clk10,
    input  logic rst,
    input  logic sw,
    input  logic nb_start,
    input  logic eco_en,
    output logic lamp,
    output logic start
);
    localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYC);

    zone_state_t state, state_d;
    logic [DEB_W-1:0] deb, deb_d;
    logic [CNT_W-1:0] tmr, tmr_d;
    logic lamp_d, start_d, sw_prev;

    always_ff @(posedge clk10 or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            deb     <= '0;
            tmr     <= '0;
            lamp    <= 1'b0;
            start   <= 1'b0;
            sw_prev <= 1'b0;
        end else begin
            state   <= state_d;
            deb     <= deb_d;
            tmr     <= tmr_d;
            lamp    <= lamp_d;
            start   <= start_d;
            sw_prev <= sw;
        end
    end

    always_comb begin
        state_d = state;
        deb_d   = deb;
        tmr_d   = tmr;
        lamp_d  = lamp;
        start_d = 1'b0;
        case (state)
            IDLE: if (sw) begin
                state_d = DEB;
                deb_d   = DEB_W'(1);
            end
            DEB: if (!sw) begin
                state_d = IDLE;
                deb_d   = '0;
            end else if (deb < DEB_MAX) begin
                deb_d = deb + 1'b1;
            end else begin
                state_d = ON;
                deb_d   = '0;
                tmr_d   = ON_LD;
                lamp_d  = 1'b1;
                start_d = 1'b1;
            end
            // a vacated zone yields to a neighbour that has just lit
            ON: if (eco_en && !sw && nb_start) begin
                state_d = IDLE;
                tmr_d   = '0;
                lamp_d  = 1'b0;
            end else if (sw && !sw_prev) begin
                tmr_d = ON_LD;
            end else if (tmr != '0) begin
                tmr_d = tmr - 1'b1;
            end else if (sw) begin
                state_d = HOLD;
                tmr_d   = HOLD_LD;
            end else begin
                state_d = IDLE;
                lamp_d  = 1'b0;
            end
            HOLD: if (!sw) begin
                state_d = IDLE;
                tmr_d   = '0;
                lamp_d  = 1'b0;
            end else if (tmr != '0) begin
                tmr_d = tmr - 1'b1;
            end else begin
                lamp_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                lamp_d  = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/corridor_light_ctrl.sv
// corridor_light_ctrl: N-zone corridor lighting with neighbour hand-off, override and lit-lamp count.
module corridor_light_ctrl
    import corridor_light_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int ON_CYC   = DEF_ON_CYC,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int ADJ_ONLY = 1
) (
    input  logic                        clk10,
    input  logic                        rst,
    input  logic [N_CH-1:0]             switch,
    input  logic                        eco_en,
    input  logic                        force_all,
    output logic [N_CH-1:0]             light,
    output logic [$clog2(N_CH+1)-1:0]   lit_cnt
);
    localparam int LC_W = $clog2(N_CH + 1);

    logic [N_CH-1:0] lamp, start, nb_start;
    logic [N_CH+1:0] start_pad;
    logic [LC_W-1:0] pop;

    // zero padding gives the end zones a single neighbour without wrap
    assign start_pad = {1'b0, start, 1'b0};

    genvar i;
    for (i = 0; i < N_CH; i++) begin : g_zone
        assign nb_start[i] = (ADJ_ONLY != 0) ? (start_pad[i] | start_pad[i+2])
                                             : |(start & ~(N_CH'(1) << i));
        corridor_light_zone #(
            .DEB_CYC (DEB_CYC),
            .ON_CYC  (ON_CYC),
            .HOLD_CYC(HOLD_CYC),
            .CNT_W   (CNT_W)
        ) u_zone (
            .clk10   (clk10),
            .rst     (rst),
            .sw      (switch[i]),
            .nb_start(nb_start[i]),
            .eco_en  (eco_en),
            .lamp    (lamp[i]),
            .start   (start[i])
        );
    end

    assign light = lamp | {N_CH{force_all}};

    always_comb begin
        pop = '0;
        for (int k = 0; k < N_CH; k++) pop = pop + LC_W'(light[k]);
    end

    always_ff @(posedge clk10 or negedge rst) begin
        if (!rst) lit_cnt <= '0;
        else      lit_cnt <= pop;
    end
endmodule

// File: tb/tb_corridor_light_ctrl.sv
// tb_corridor_light_ctrl: directed stimulus against a cycles-remaining occupancy model plus literal checks.
module tb_corridor_light_ctrl;
    localparam int N = 3, DEB = 4, ONC = 80, HOLDC = 40;

    logic clk10 = 1'b0, rst = 1'b0, eco_en = 1'b0, force_all = 1'b0;
    logic [N-1:0] sw = '0;
    logic [N-1:0] light;
    logic [1:0]   lit_cnt;
    int total = 0, bad = 0;
    int n;

    corridor_light_ctrl dut (
        .clk10    (clk10),
        .rst      (rst),
        .switch   (sw),
        .eco_en   (eco_en),
        .force_all(force_all),
        .light    (light),
        .lit_cnt  (lit_cnt)
    );

    always #5 clk10 = ~clk10;

    // model: 0 dark, 1 on-window, 2 hold-window, 3 dark but still occupied
    int mode[N], win[N], run[N];
    bit pstart[N], psw[N], ns[N];
    int exp_cnt = 0;

    function automatic logic [N-1:0] model_lamps();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = (mode[i] == 1 || mode[i] == 2);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk10 or negedge rst);
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                mode[i] = 0; win[i] = 0; run[i] = 0; pstart[i] = 0; psw[i] = 0;
            end
            exp_cnt = 0;
        end else begin
            logic [N-1:0] cur;
            cur = model_lamps() | {N{force_all}};
            exp_cnt = 0;
            for (int k = 0; k < N; k++) exp_cnt += int'(cur[k]);
            for (int i = 0; i < N; i++) begin
                bit s, rise, nb;
                s    = sw[i];
                rise = s && !psw[i];
                nb   = (i > 0 ? pstart[i-1] : 1'b0) || (i < N-1 ? pstart[i+1] : 1'b0);
                ns[i] = 0;
                case (mode[i])
                    0: if (s) begin
                        run[i]++;
                        if (run[i] == DEB + 1) begin
                            mode[i] = 1; win[i] = ONC; run[i] = 0; ns[i] = 1;
                        end
                    end else run[i] = 0;
                    1: if (eco_en && !s && nb) mode[i] = 0;
                       else if (rise) win[i] = ONC;
                       else begin
                           win[i]--;
                           if (win[i] == 0) begin
                               if (s) begin mode[i] = 2; win[i] = HOLDC; end
                               else mode[i] = 0;
                           end
                       end
                    2: if (!s) mode[i] = 0;
                       else begin
                           win[i]--;
                           if (win[i] == 0) mode[i] = 3;
                       end
                    default: if (!s) mode[i] = 0;
                endcase
            end
            for (int i = 0; i < N; i++) begin
                pstart[i] = ns[i];
                psw[i]    = sw[i];
            end
        end
    end

    initial forever begin
        @(negedge clk10);
        check("light_model", light, model_lamps() | {N{force_all}});
        check("cnt_model", lit_cnt, exp_cnt);
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk10);
        #2;
    endtask

    // counts edges until zone ch goes dark; optionally drops its switch and pulses another switch
    task automatic run_lit(input int ch, input int rel, input int oth, input int oth_at,
                           input int oth_len, output int cnt);
        cnt = 0;
        while (light[ch] === 1'b1 && cnt < 400) begin
            if (cnt == rel) sw[ch] = 1'b0;
            if (oth >= 0 && cnt == oth_at) sw[oth] = 1'b1;
            if (oth >= 0 && cnt == oth_at + oth_len) sw[oth] = 1'b0;
            cyc(1);
            cnt++;
        end
    endtask

    initial begin
        cyc(3);
        check("rst_light", light, 0);
        check("rst_cnt", lit_cnt, 0);
        rst = 1'b1;
        cyc(2);

        sw[0] = 1'b1; cyc(3); sw[0] = 1'b0; cyc(8);
        check("deb_short", light, 0);
        sw[0] = 1'b1; cyc(4);
        check("deb_edge4", light[0], 0);
        cyc(1);
        check("deb_edge5", light[0], 1);
        run_lit(0, 0, -1, -1, 0, n);
        check("deb_len", n, 80);
        cyc(3);

        sw[1] = 1'b1; cyc(5);
        check("to_rise", light[1], 1);
        check("to_cnt_lag", lit_cnt, 0);
        run_lit(1, 1, -1, -1, 0, n);
        check("to_len", n, 80);
        check("to_cnt_tail", lit_cnt, 1);
        cyc(1);
        check("to_cnt_zero", lit_cnt, 0);

        sw[2] = 1'b1; cyc(5);
        check("hold_rise", light[2], 1);
        run_lit(2, 1000, -1, -1, 0, n);
        check("hold_len", n, 120);
        cyc(5);
        check("hold_stationary", light[2], 0);
        sw[2] = 1'b0; cyc(2);
        sw[2] = 1'b1; cyc(5);
        check("hold_rearm", light[2], 1);
        run_lit(2, 0, -1, -1, 0, n);
        check("rearm_len", n, 80);
        cyc(2);

        eco_en = 1'b1;
        sw[0] = 1'b1; cyc(5); sw[0] = 1'b0; cyc(3);
        sw[1] = 1'b1; cyc(5);
        check("ho_both", light, 3'b011);
        cyc(1);
        check("ho_drop", light, 3'b010);
        sw[1] = 1'b0; cyc(100);

        eco_en = 1'b0;
        sw[0] = 1'b1; cyc(5);
        run_lit(0, 0, 1, 3, 5, n);
        check("no_eco_len", n, 80);
        cyc(100);

        eco_en = 1'b1;
        sw[0] = 1'b1; cyc(5);
        run_lit(0, 0, 2, 3, 5, n);
        check("adj_only_len", n, 80);
        cyc(100);
        eco_en = 1'b0;

        sw[0] = 1'b1; cyc(5);
        run_lit(0, 0, 0, 69, 1, n);
        check("retrig_len", n, 150);
        cyc(3);

        force_all = 1'b1; #1;
        check("force_light", light, 3'b111);
        cyc(1);
        check("force_cnt", lit_cnt, 3);
        force_all = 1'b0; #1;
        check("force_release", light, 0);
        cyc(1);
        check("force_cnt_off", lit_cnt, 0);

        sw[1] = 1'b1; cyc(5); sw[1] = 1'b0;
        check("rst_pre_on", light, 3'b010);
        cyc(3);
        rst = 1'b0; #1;
        check("rst_async_light", light, 0);
        check("rst_async_cnt", lit_cnt, 0);
        cyc(2);
        rst = 1'b1;
        cyc(10);
        check("rst_no_relight", light, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
